// File: rtl/ext_port_responder.sv
// ext_port_responder
// Stands in for the outside world on the processor's four 8-bit I/O ports.
// Each processor output access is captured once into a small show-ahead FIFO
// that a host drains. The input-port values the processor reads are held in
// registers that the host reloads through a load handshake.
module ext_port_responder #(
    parameter int          DEPTH   = 4,
    parameter logic [31:0] INIT_IN = 32'h3C03_0C04
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic [7:0]                 OutExtWorld1,
    input  logic [7:0]                 OutExtWorld2,
    input  logic [7:0]                 OutExtWorld3,
    input  logic [7:0]                 OutExtWorld4,
    input  logic                       OUTportWrite,
    output logic [7:0]                 InpExtWorld1,
    output logic [7:0]                 InpExtWorld2,
    output logic [7:0]                 InpExtWorld3,
    output logic [7:0]                 InpExtWorld4,
    input  logic                       host_load_valid,
    input  logic [31:0]                host_load_data,
    output logic                       host_load_ready,
    output logic                       in_update,
    output logic                       cap_valid,
    output logic [31:0]                cap_data,
    input  logic                       cap_ready,
    output logic [$clog2(DEPTH):0]     cap_count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic              r_strobeQ;
    logic [31:0]       r_mem [DEPTH];
    logic [AW-1:0]     r_wrPtr;
    logic [AW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic [31:0]       r_inpWord;
    logic              r_inUpdate;

    logic              w_captureEvent;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_doPush;
    logic              w_loadAccept;
    logic [31:0]       w_pushData;

    // A full FIFO still accepts a push when the head is popped on the same
    // edge, since the pop frees the slot the push fills.
    assign w_captureEvent = OUTportWrite & ~r_strobeQ;
    assign w_empty        = (r_count == '0);
    assign w_full         = (r_count == CW'(DEPTH));
    assign w_pop          = ~w_empty & cap_ready;
    assign w_doPush       = w_captureEvent & (~w_full | w_pop);
    assign w_pushData     = {OutExtWorld4, OutExtWorld3, OutExtWorld2, OutExtWorld1};
    assign w_loadAccept   = host_load_valid & host_load_ready;

    assign host_load_ready = ~OUTportWrite & ~r_strobeQ;
    assign cap_valid       = ~w_empty;
    assign cap_count       = r_count;
    assign cap_data        = w_empty ? 32'h0 : r_mem[r_rdPtr];
    assign overflow        = r_overflow;
    assign in_update       = r_inUpdate;
    assign InpExtWorld1    = r_inpWord[7:0];
    assign InpExtWorld2    = r_inpWord[15:8];
    assign InpExtWorld3    = r_inpWord[23:16];
    assign InpExtWorld4    = r_inpWord[31:24];

    // Strobe history for edge detection; cleared so a strobe held through reset counts as new.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_strobeQ <= 1'b0;
        end else begin
            r_strobeQ <= OUTportWrite;
        end
    end

    // Capture FIFO storage, pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0;
            end
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= w_pushData;
                r_wrPtr        <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_doPush && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_doPush) begin
                r_count <= r_count - CW'(1);
            end
            if (w_captureEvent && !w_doPush) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Input-port registers reloaded by the host, with a one-cycle update pulse.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_inpWord  <= INIT_IN;
            r_inUpdate <= 1'b0;
        end else begin
            r_inUpdate <= w_loadAccept;
            if (w_loadAccept) begin
                r_inpWord <= host_load_data;
            end
        end
    end

endmodule

// File: tb/tb_ext_port_responder.sv
// tb_ext_port_responder
// Directed table of single-cycle vectors followed by hand-written sequences
// for overflow, reset with queued data, and pointer wrap.
module tb_ext_port_responder;

    logic        clk = 1'b0;
    logic        Reset;
    logic [7:0]  OutExtWorld1, OutExtWorld2, OutExtWorld3, OutExtWorld4;
    logic        OUTportWrite;
    logic [7:0]  InpExtWorld1, InpExtWorld2, InpExtWorld3, InpExtWorld4;
    logic        host_load_valid;
    logic [31:0] host_load_data;
    logic        host_load_ready;
    logic        in_update;
    logic        cap_valid;
    logic [31:0] cap_data;
    logic        cap_ready;
    logic [2:0]  cap_count;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] INIT = 32'h3C03_0C04;

    ext_port_responder #(.DEPTH(4), .INIT_IN(INIT)) dut (
        .clk             (clk),
        .Reset           (Reset),
        .OutExtWorld1    (OutExtWorld1),
        .OutExtWorld2    (OutExtWorld2),
        .OutExtWorld3    (OutExtWorld3),
        .OutExtWorld4    (OutExtWorld4),
        .OUTportWrite    (OUTportWrite),
        .InpExtWorld1    (InpExtWorld1),
        .InpExtWorld2    (InpExtWorld2),
        .InpExtWorld3    (InpExtWorld3),
        .InpExtWorld4    (InpExtWorld4),
        .host_load_valid (host_load_valid),
        .host_load_data  (host_load_data),
        .host_load_ready (host_load_ready),
        .in_update       (in_update),
        .cap_valid       (cap_valid),
        .cap_data        (cap_data),
        .cap_ready       (cap_ready),
        .cap_count       (cap_count),
        .overflow        (overflow)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    typedef struct {
        logic        strobe;
        logic [31:0] outData;
        logic        capReady;
        logic        loadValid;
        logic [31:0] loadData;
        logic        expValid;
        int          expCount;
        logic [31:0] expData;
        logic        expOvf;
        logic [31:0] expInp;
        logic        expReady;
        logic        expUpd;
    } vec_t;

    vec_t vecs [13];
    logic [31:0] model [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setOut(input logic [31:0] w);
        {OutExtWorld4, OutExtWorld3, OutExtWorld2, OutExtWorld1} = w;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        OUTportWrite    = v.strobe;
        setOut(v.outData);
        cap_ready       = v.capReady;
        host_load_valid = v.loadValid;
        host_load_data  = v.loadData;
    endtask

    task automatic doStrobe(input logic [31:0] w);
        OUTportWrite = 1'b1;
        setOut(w);
        step();
        OUTportWrite = 1'b0;
        setOut(32'h0);
        step();
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " cap_valid"}, 32'(cap_valid), 32'd0);
        checkOutput({tag, " cap_count"}, 32'(cap_count), 32'd0);
        checkOutput({tag, " cap_data"}, cap_data, 32'h0);
        checkOutput({tag, " overflow"}, 32'(overflow), 32'd0);
        checkOutput({tag, " in_update"}, 32'(in_update), 32'd0);
        checkOutput({tag, " inp"}, {InpExtWorld4, InpExtWorld3, InpExtWorld2, InpExtWorld1}, INIT);
    endtask

    localparam logic [31:0] LA = 32'hA0B0C0D0;
    localparam logic [31:0] LB = 32'h11111111;

    initial begin
        Reset = 1'b1;
        OUTportWrite = 1'b0;
        setOut(32'h0);
        cap_ready = 1'b0;
        host_load_valid = 1'b0;
        host_load_data = 32'h0;

        vecs[0]  = '{1'b1, 32'h44332211, 1'b0, 1'b0, 32'h0, 1'b1, 1, 32'h44332211, 1'b0, INIT, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'h44332211, 1'b0, 1'b0, 32'h0, 1'b1, 1, 32'h44332211, 1'b0, INIT, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'h44332211, 1'b0, 1'b0, 32'h0, 1'b1, 1, 32'h44332211, 1'b0, INIT, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0, 1'b1, 1, 32'h44332211, 1'b0, INIT, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, LA,    1'b1, 1, 32'h44332211, 1'b0, LA,   1'b1, 1'b1};
        vecs[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0, 1'b1, 1, 32'h44332211, 1'b0, LA,   1'b1, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b0, 0, 32'h0,        1'b0, LA,   1'b1, 1'b0};
        vecs[7]  = '{1'b1, 32'h55667788, 1'b1, 1'b0, 32'h0, 1'b1, 1, 32'h55667788, 1'b0, LA,   1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b0, 0, 32'h0,        1'b0, LA,   1'b1, 1'b0};
        vecs[9]  = '{1'b1, 32'h01020304, 1'b0, 1'b1, LB,    1'b1, 1, 32'h01020304, 1'b0, LA,   1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b1, LB,    1'b1, 1, 32'h01020304, 1'b0, LA,   1'b1, 1'b0};
        vecs[11] = '{1'b0, 32'h0,        1'b0, 1'b1, LB,    1'b1, 1, 32'h01020304, 1'b0, LB,   1'b1, 1'b1};
        vecs[12] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b0, 0, 32'h0,        1'b0, LB,   1'b1, 1'b0};

        step();
        step();
        Reset = 1'b0;
        checkReset("reset");
        checkOutput("reset host_load_ready", 32'(host_load_ready), 32'd1);

        // Table-driven single-cycle vectors
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            step();
            checkOutput($sformatf("vec%0d cap_valid", i), 32'(cap_valid), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d cap_count", i), 32'(cap_count), 32'(vecs[i].expCount));
            checkOutput($sformatf("vec%0d cap_data", i), cap_data, vecs[i].expData);
            checkOutput($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].expOvf));
            checkOutput($sformatf("vec%0d inp", i),
                        {InpExtWorld4, InpExtWorld3, InpExtWorld2, InpExtWorld1}, vecs[i].expInp);
            checkOutput($sformatf("vec%0d ready", i), 32'(host_load_ready), 32'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d in_update", i), 32'(in_update), 32'(vecs[i].expUpd));
        end
        applyStimulus('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 0, 32'h0, 1'b0, LB, 1'b1, 1'b0});
        step();

        // Overflow: five strobes into a four-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            doStrobe(32'h10203040 + 32'(i));
            if (i == 4) begin
                checkOutput("ovf fill4 count", 32'(cap_count), 32'd4);
                checkOutput("ovf fill4 flag", 32'(overflow), 32'd0);
            end
        end
        checkOutput("ovf fill5 count", 32'(cap_count), 32'd4);
        checkOutput("ovf fill5 flag", 32'(overflow), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("ovf drain%0d", i), cap_data, 32'h10203040 + 32'(i));
            cap_ready = 1'b1;
            step();
            cap_ready = 1'b0;
        end
        checkOutput("ovf drained valid", 32'(cap_valid), 32'd0);
        checkOutput("ovf drained data", cap_data, 32'h0);

        // Full FIFO with a push and pop on the same edge
        for (int i = 6; i <= 9; i++) begin
            doStrobe(32'h10203040 + 32'(i));
        end
        OUTportWrite = 1'b1;
        setOut(32'h1020304A);
        cap_ready = 1'b1;
        step();
        cap_ready = 1'b0;
        checkOutput("fullpp count", 32'(cap_count), 32'd4);
        checkOutput("fullpp head", cap_data, 32'h10203047);
        checkOutput("fullpp overflow", 32'(overflow), 32'd1);
        OUTportWrite = 1'b0;
        setOut(32'h0);
        step();
        for (int i = 7; i <= 10; i++) begin
            checkOutput($sformatf("fullpp drain%0d", i), cap_data, 32'h10203040 + 32'(i));
            cap_ready = 1'b1;
            step();
            cap_ready = 1'b0;
        end
        checkOutput("fullpp drained count", 32'(cap_count), 32'd0);

        // Reset with entries queued and overflow set, strobe held through release
        for (int i = 0; i < 3; i++) begin
            doStrobe(32'h20000000 + 32'(i));
        end
        checkOutput("prerst count", 32'(cap_count), 32'd3);
        checkOutput("prerst overflow", 32'(overflow), 32'd1);
        Reset = 1'b1;
        OUTportWrite = 1'b1;
        setOut(32'hCAFEBABE);
        step();
        checkReset("midrst");
        checkOutput("midrst ready", 32'(host_load_ready), 32'd0);
        step();
        Reset = 1'b0;
        step();
        checkOutput("postrst count", 32'(cap_count), 32'd1);
        checkOutput("postrst data", cap_data, 32'hCAFEBABE);
        step();
        step();
        checkOutput("postrst held count", 32'(cap_count), 32'd1);
        OUTportWrite = 1'b0;
        setOut(32'h0);
        cap_ready = 1'b1;
        step();
        cap_ready = 1'b0;
        checkOutput("postrst drained", 32'(cap_count), 32'd0);

        // Pointer wrap: interleaved push/pop pairs with one entry of slack
        model.delete();
        doStrobe(32'h30000000);
        model.push_back(32'h30000000);
        for (int i = 1; i <= 10; i++) begin
            OUTportWrite = 1'b1;
            setOut(32'h30000000 + 32'(i));
            cap_ready = 1'b1;
            step();
            model.push_back(32'h30000000 + 32'(i));
            void'(model.pop_front());
            OUTportWrite = 1'b0;
            setOut(32'h0);
            cap_ready = 1'b0;
            step();
            checkOutput($sformatf("wrap%0d head", i), cap_data, model[0]);
            checkOutput($sformatf("wrap%0d count", i), 32'(cap_count), 32'(model.size()));
            if (cap_count > 3'd4) begin
                checkOutput($sformatf("wrap%0d count bound", i), 32'(cap_count), 32'd4);
            end
        end
        cap_ready = 1'b1;
        step();
        cap_ready = 1'b0;
        checkOutput("wrap final valid", 32'(cap_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ext_port_responder.md
# ext_port_responder

External-world responder for the RISC processor's four 8-bit I/O ports. The processor writes OutExtWorld1..4 and asserts the OUTportWrite strobe. This block captures each write into a small FIFO that a host drains through a valid/ready handshake. In the other direction, it holds the InpExtWorld1..4 values that the processor reads, and a host updates them through a load handshake. It sits outside the processor wrapper, in the benches and on the top-level board shell, in place of the fixed stimulus registers.

## Interface
- DEPTH, 4: capture FIFO depth in entries; power of 2, minimum 2.
- INIT_IN, 32'h3C03_0C04: reset value of the input ports; bits [7:0] drive port 1 and bits [31:24] drive port 4.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- OutExtWorld1..4  in  8 each  processor output port values.
- OUTportWrite  in  1  processor output strobe; a level that may stay high for several cycles per access.
- InpExtWorld1..4  out  8 each  processor input port values; registered.
- host_load_valid  in  1  host offers a new input-port word.
- host_load_data  in  32  new input-port word, {port4, port3, port2, port1}.
- host_load_ready  out  1  block accepts a load this cycle.
- in_update  out  1  one-cycle pulse in the cycle after a load is accepted.
- cap_valid  out  1  capture FIFO is non-empty.
- cap_data  out  32  FIFO head, {OutExtWorld4, 3, 2, 1}.
- cap_ready  in  1  host pops the FIFO head.
- cap_count  out  clog2(DEPTH)+1  number of entries held.
- overflow  out  1  sticky flag: a capture was dropped.

## Operation
- Strobe edge detect:
  - strobe_q is a registered copy of OUTportWrite.
  - A capture event occurs on an edge where OUTportWrite=1 and strobe_q=0.
  - Exactly one capture happens per strobe assertion, however long the strobe stays high.
- Capture: on the event edge, the block pushes {OutExtWorld4..1} as sampled on that edge.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy count.
  - cap_data is the head entry (show-ahead). It is X-free; it reads 0 when empty.
  - A pop occurs on an edge where cap_valid && cap_ready; cap_ready while empty is ignored.
  - Pointers wrap modulo DEPTH.
- Boundary rules:
  - Push and pop on the same edge with count in 1..DEPTH: both are performed and count is unchanged. When full, this means the pop frees the slot the push fills.
  - Push while full with no pop: the data is dropped, overflow is set, and pointers and count are unchanged.
  - Push while empty with a cap_ready: no pop occurs; the entry appears on the next cycle.
  - overflow clears only on Reset.
- Load path:
  - host_load_ready = ~OUTportWrite & ~strobe_q. Loads are held off during a processor I/O access and for one cycle after it.
  - On an edge with host_load_valid && host_load_ready, host_load_data is written to the InpExtWorld registers and in_update pulses high for the following cycle.
  - A valid while not ready is not accepted. The host must hold valid and data until ready.
- Reset (synchronous, any cycle, including mid-access or mid-load):
  - InpExtWorld = INIT_IN bytes.
  - FIFO emptied: cap_valid=0, cap_count=0, cap_data=0.
  - overflow=0, in_update=0, strobe_q=0.
  - host_load_ready then follows OUTportWrite combinationally.
  - A strobe that is already high when Reset drops counts as a new rising edge on the first edge after reset.

## Timing
- Capture latency: capture event at edge k gives cap_valid=1, cap_count+1 and updated cap_data from just after edge k (one cycle).
- Pop: the next head is visible just after the pop edge. Back-to-back pops are allowed every cycle.
- Throughput: at most one capture per two cycles, limited by the strobe low/high cycle. The FIFO accepts a push on every edge.
- Load: InpExtWorld changes just after the accepting edge; in_update is high for exactly that cycle.
- No combinational path from OUTportWrite to any output except host_load_ready.

## Test plan
- Reset with the defaults: InpExtWorld1..4 = 04, 0C, 03, 3C; cap_valid=0; overflow=0; host_load_ready=1.
- OutExtWorld = 11, 22, 33, 44 with OUTportWrite held high for 3 cycles, cap_ready=0: exactly one entry, cap_data=32'h44332211, cap_count=1.
- Five strobes with DEPTH=4 and cap_ready=0: cap_count=4, overflow=1, and a drain returns only the first four words in order. Then a simultaneous push and pop while full: count stays 4 and the new word ends up last.
- Load 32'hA0B0C0D0 with the strobe low: InpExtWorld1..4 = D0, C0, B0, A0 on the next cycle, with an in_update pulse of exactly 1 cycle. Repeat with the strobe high: ready=0, nothing is loaded until two cycles after the strobe falls.
- Reset asserted with 3 entries queued and overflow=1: all outputs return to their reset values on the next edge. A strobe held high through the reset release is captured once.
- Wrap: 10 push/pop pairs interleaved with DEPTH=4: data returns in order across pointer wrap, and cap_count never exceeds 4.
